// File: rtl/counter_ctrl_pkg.sv
// rtl/counter_ctrl_pkg.sv - command bytes, state encodings and byte decode for counter_cmd_ctrl
package counter_ctrl_pkg;

  localparam logic [7:0] CMD_RUN_U  = 8'h52;
  localparam logic [7:0] CMD_RUN_L  = 8'h72;
  localparam logic [7:0] CMD_CLR_U  = 8'h43;
  localparam logic [7:0] CMD_CLR_L  = 8'h63;
  localparam logic [7:0] CMD_MODE_U = 8'h4D;
  localparam logic [7:0] CMD_MODE_L = 8'h6D;

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } ctrl_state_t;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_WAIT = 2'd1,
    F_DEC  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic run;
    logic clr;
    logic mode;
    logic err;
  } cmd_evt_t;

  function automatic cmd_evt_t decode_byte(input logic [7:0] b);
    cmd_evt_t e;
    e = '0;
    case (b)
      CMD_RUN_U,  CMD_RUN_L:  e.run  = 1'b1;
      CMD_CLR_U,  CMD_CLR_L:  e.clr  = 1'b1;
      CMD_MODE_U, CMD_MODE_L: e.mode = 1'b1;
      default:                e.err  = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/counter_cmd_ctrl_if.sv
// rtl/counter_cmd_ctrl_if.sv - FIFO, button and counter-control signals of counter_cmd_ctrl
interface counter_cmd_ctrl_if;
  logic       i_fifo_empty;
  logic [7:0] i_fifo_rdata;
  logic       o_fifo_rd;
  logic       i_btn_run;
  logic       i_btn_clear;
  logic       i_btn_mode;
  logic       o_tick;
  logic       o_mode;
  logic       o_clear;
  logic       o_run;
  logic       o_cmd_err;

  modport master (
    output i_fifo_empty, i_fifo_rdata, i_btn_run, i_btn_clear, i_btn_mode,
    input  o_fifo_rd, o_tick, o_mode, o_clear, o_run, o_cmd_err
  );

  modport slave (
    input  i_fifo_empty, i_fifo_rdata, i_btn_run, i_btn_clear, i_btn_mode,
    output o_fifo_rd, o_tick, o_mode, o_clear, o_run, o_cmd_err
  );
endinterface

// File: rtl/counter_cmd_ctrl_tick_gen.sv
// rtl/counter_cmd_ctrl_tick_gen.sv - tick prescaler, counts only while enabled so a stop keeps the phase
module tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic o_tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

  assign o_tick = en && (cnt == LAST);

endmodule

// File: rtl/counter_cmd_ctrl.sv
// rtl/counter_cmd_ctrl.sv - UART/button command fetch, decode, merge and run/stop/mode control
module counter_cmd_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100
) (
  input logic               clk,
  input logic               rst,
  counter_cmd_ctrl_if.slave bus
);

  localparam int DIV = CLK_HZ / TICK_HZ;

  fetch_state_t f_state, f_next;
  ctrl_state_t  c_state, c_next;
  logic [7:0]   cmd_byte;
  logic         fifo_rd;
  cmd_evt_t     uart_evt;
  logic         run_ev, clr_ev, mode_ev;
  logic         mode_q, clear_q, err_q;
  logic         tick_raw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_state  <= F_IDLE;
      cmd_byte <= '0;
    end else begin
      f_state <= f_next;
      if (f_state == F_WAIT) cmd_byte <= bus.i_fifo_rdata;
    end
  end

  always_comb begin
    f_next  = f_state;
    fifo_rd = 1'b0;
    case (f_state)
      F_IDLE: begin
        if (!bus.i_fifo_empty) begin
          fifo_rd = 1'b1;
          f_next  = F_WAIT;
        end
      end
      F_WAIT:  f_next = F_DEC;
      F_DEC:   f_next = F_IDLE;
      default: f_next = F_IDLE;
    endcase
  end

  // Held in reset the fetch FSM sits in F_IDLE; keep the pop strobe low there too.
  assign bus.o_fifo_rd = fifo_rd & rst;

  always_comb begin
    uart_evt = '0;
    if (f_state == F_DEC) uart_evt = decode_byte(cmd_byte);
  end

  assign run_ev  = uart_evt.run  | bus.i_btn_run;
  assign clr_ev  = uart_evt.clr  | bus.i_btn_clear;
  assign mode_ev = uart_evt.mode | bus.i_btn_mode;

  always_comb begin
    c_next = c_state;
    if (clr_ev) begin
      c_next = STOP;
    end else if (run_ev) begin
      c_next = (c_state == STOP) ? RUN : STOP;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_state <= STOP;
      mode_q  <= 1'b0;
      clear_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      c_state <= c_next;
      mode_q  <= mode_q ^ mode_ev;
      clear_q <= clr_ev;
      err_q   <= uart_evt.err;
    end
  end

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .en     (c_state == RUN),
    .clr    (clr_ev),
    .o_tick (tick_raw)
  );

  assign bus.o_tick    = tick_raw & ~clear_q;
  assign bus.o_run     = (c_state == RUN);
  assign bus.o_mode    = mode_q;
  assign bus.o_clear   = clear_q;
  assign bus.o_cmd_err = err_q;

endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// tb/tb_counter_cmd_ctrl.sv - scoreboard bench for counter_cmd_ctrl against a behavioural model
module tb_counter_cmd_ctrl;

  localparam int DIV = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  counter_cmd_ctrl_if bus();

  counter_cmd_ctrl #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] bq[$];
  logic [7:0] mq[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  bit         rd_seen = 0;

  bit         m_run, m_mode, m_clr, m_err, m_pend;
  int         m_presc, m_pend_cyc, m_next_free;
  logic [7:0] m_pend_byte;
  bit         p_run, p_mode;

  function automatic string kname(input int k);
    case (k)
      0: return "fifo_rd";
      1: return "tick";
      2: return "clear";
      3: return "cmd_err";
      4: return "run_rise";
      5: return "run_fall";
      6: return "mode_rise";
      default: return "mode_fall";
    endcase
  endfunction

  task automatic push_exp(input int k);
    ev_t e;
    e.kind = k;
    e.cyc  = cyc;
    exp_q.push_back(e);
  endtask

  // Reference: each cycle yields the visible outputs, then applies that cycle's events.
  task automatic model_cycle(input bit br, input bit bc, input bit bm);
    bit o_run, o_mode, o_clr, o_err, o_tick, o_rd;
    bit ur, uc, um, bad, ev_r, ev_c, ev_m;
    {o_run, o_mode, o_clr, o_err, o_tick, o_rd} = '0;
    {ur, uc, um, bad} = '0;
    if (!rst_n) begin
      {m_run, m_mode, m_clr, m_err, m_pend} = '0;
      m_presc = 0;
      m_next_free = 0;
    end else begin
      o_run  = m_run;
      o_mode = m_mode;
      o_clr  = m_clr;
      o_err  = m_err;
      o_tick = m_run && (m_presc == DIV - 1) && !m_clr;
      o_rd   = (mq.size() > 0) && (cyc >= m_next_free);
      if (o_rd) begin
        m_pend_byte = mq.pop_front();
        m_pend      = 1;
        m_pend_cyc  = cyc + 2;
        m_next_free = cyc + 3;
      end
      if (m_pend && m_pend_cyc == cyc) begin
        m_pend = 0;
        case (m_pend_byte)
          8'h52, 8'h72: ur = 1;
          8'h43, 8'h63: uc = 1;
          8'h4D, 8'h6D: um = 1;
          default:      bad = 1;
        endcase
      end
      ev_r = br | ur;
      ev_c = bc | uc;
      ev_m = bm | um;
      if (ev_c) begin
        m_run   = 0;
        m_presc = 0;
      end else begin
        if (m_run) m_presc = (m_presc + 1) % DIV;
        if (ev_r) m_run = !m_run;
      end
      if (ev_m) m_mode = !m_mode;
      m_clr = ev_c;
      m_err = bad;
    end
    if (o_rd)             push_exp(0);
    if (o_tick)           push_exp(1);
    if (o_clr)            push_exp(2);
    if (o_err)            push_exp(3);
    if (o_run && !p_run)  push_exp(4);
    if (!o_run && p_run)  push_exp(5);
    if (o_mode && !p_mode) push_exp(6);
    if (!o_mode && p_mode) push_exp(7);
    p_run  = o_run;
    p_mode = o_mode;
  endtask

  task automatic step(input bit br = 0, input bit bc = 0, input bit bm = 0, input bit rs = 1);
    @(posedge clk);
    #1;
    cyc++;
    if (rd_seen && bq.size() > 0) bus.i_fifo_rdata = bq.pop_front();
    else bus.i_fifo_rdata = 8'($urandom);
    rd_seen = 0;
    bus.i_fifo_empty = (bq.size() == 0);
    bus.i_btn_run    = br;
    bus.i_btn_clear  = bc;
    bus.i_btn_mode   = bm;
    rst_n            = rs;
    model_cycle(br, bc, bm);
  endtask

  task automatic push_byte(input logic [7:0] b);
    bq.push_back(b);
    mq.push_back(b);
  endtask

  task automatic check_zero(input string name);
    logic [5:0] got;
    got = {bus.o_fifo_rd, bus.o_tick, bus.o_mode, bus.o_clear, bus.o_run, bus.o_cmd_err};
    vectors++;
    if (got != 6'b0) begin
      miscompares++;
      $display("FAIL %s: outputs {rd,tick,mode,clear,run,err}=%b, required 000000", name, got);
    end
  endtask

  bit d_prun = 0, d_pmode = 0;

  always @(negedge clk) begin
    bit got[8];
    int idx;
    got[0] = bus.o_fifo_rd;
    got[1] = bus.o_tick;
    got[2] = bus.o_clear;
    got[3] = bus.o_cmd_err;
    got[4] = bus.o_run && !d_prun;
    got[5] = !bus.o_run && d_prun;
    got[6] = bus.o_mode && !d_pmode;
    got[7] = !bus.o_mode && d_pmode;
    d_prun  = bus.o_run;
    d_pmode = bus.o_mode;
    rd_seen = bus.o_fifo_rd;
    if (bus.o_fifo_rd) begin
      vectors++;
      if (bus.i_fifo_empty) begin
        miscompares++;
        $display("FAIL rd_when_empty: cycle %0d fifo_rd=1 with fifo_empty=1, required fifo_rd=0", cyc);
      end
    end
    for (int k = 0; k < 8; k++) begin
      if (got[k]) begin
        vectors++;
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++)
          if (idx < 0 && exp_q[i].kind == k && exp_q[i].cyc == cyc) idx = i;
        if (idx >= 0) exp_q.delete(idx);
        else begin
          miscompares++;
          $display("FAIL %s: seen at cycle %0d, required none at this cycle", kname(k), cyc);
        end
      end
    end
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: not seen, required at cycle %0d", kname(exp_q[0].kind), exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
  end

  logic [7:0] tbl[6] = '{8'h52, 8'h72, 8'h43, 8'h63, 8'h4D, 8'h6D};

  initial begin
    bit found;
    bit br, bc, bm;
    bus.i_fifo_empty = 1'b1;
    bus.i_fifo_rdata = 8'h00;
    bus.i_btn_run    = 1'b0;
    bus.i_btn_clear  = 1'b0;
    bus.i_btn_mode   = 1'b0;

    repeat (3) begin
      step(0, 0, 0, 0);
      #1 check_zero("reset_state");
    end
    repeat (50) step();

    push_byte(8'h72);
    repeat (45) step();
    push_byte(8'h52);
    repeat (10) step();
    push_byte(8'h72);
    repeat (20) step();

    repeat (3) step();
    step(1, 1, 0);
    repeat (15) step();

    step(1, 0, 0);
    repeat (5) step();
    push_byte(8'h6D);
    repeat (25) step();

    push_byte(8'h4D);
    step();
    step();
    step(0, 0, 1);
    repeat (5) step();

    push_byte(8'h41);
    push_byte(8'h72);
    push_byte(8'h63);
    repeat (15) step();

    if (!m_run) step(1, 0, 0);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (m_run && m_presc == 7) found = 1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL presc_seek: prescaler 7 in RUN not reached within 40 cycles, required reached");
    end
    step(0, 0, 0, 0);
    #1 check_zero("reset_mid_run");
    step(0, 0, 0, 0);
    step();
    push_byte(8'h72);
    repeat (20) step();

    repeat (3000) begin
      br = ($urandom_range(0, 39) == 0);
      bc = ($urandom_range(0, 79) == 0);
      bm = ($urandom_range(0, 49) == 0);
      if (bq.size() < 3 && $urandom_range(0, 11) == 0) begin
        if ($urandom_range(0, 6) == 6) push_byte(8'($urandom));
        else push_byte(tbl[$urandom_range(0, 5)]);
      end
      step(br, bc, bm);
    end
    repeat (12) step();

    @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected events left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
